// File: rtl/sram_req_arbiter.sv
// sram_req_arbiter
//   Shares one SRAM-like memory port (req / addr_ok / data_ok handshake) between
//   the instruction-fetch requester (inst_*) and the data requester (data_*).
//   Data has fixed priority over inst. A granted request that has not yet been
//   accepted stays locked on the bus until sram_addr_ok. Every accepted request
//   pushes its source ID into a small in-order FIFO. Each sram_data_ok pops that
//   FIFO and is routed to the owning requester.
//
// Ports
//   clk, resetn            clock, synchronous active-low reset
//   inst_req..inst_wdata   instruction-side request (wr, size, wstrb, addr, wdata)
//   inst_addr_ok           instruction request accepted this cycle
//   inst_data_ok/rdata     instruction response
//   data_req..data_wdata   data-side request, same fields as inst_*
//   data_addr_ok           data request accepted this cycle
//   data_data_ok/rdata     data response
//   sram_req..sram_wdata   muxed request towards the memory bridge
//   sram_addr_ok           memory accepted the request
//   sram_data_ok/rdata     memory response
//   err_unexp              sticky: response arrived with no request outstanding
//
// Lock state
//   locked | meaning
//   0      | bus free, grant follows priority (data over inst)
//   1      | request of lock_id is on the bus waiting for sram_addr_ok
module sram_req_arbiter #(
  parameter int MAX_OUTST = 2,
  parameter int CNT_W     = 2
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  output logic        sram_req,
  output logic        sram_wr,
  output logic [1:0]  sram_size,
  output logic [3:0]  sram_wstrb,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic        sram_addr_ok,
  input  logic        sram_data_ok,
  input  logic [31:0] sram_rdata,

  output logic        err_unexp
);

  localparam logic ID_INST = 1'b0;
  localparam logic ID_DATA = 1'b1;

  localparam int               PTR_W    = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTST - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTST);

  logic                 locked;
  logic                 lock_id;
  logic [CNT_W-1:0]     count;
  logic [PTR_W-1:0]     head;
  logic [PTR_W-1:0]     tail;
  logic [MAX_OUTST-1:0] id_fifo;
  logic                 err_q;

  logic grant;
  logic full;
  logic empty;
  logic push;
  logic pop;
  logic head_id;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_LAST)
      return '0;
    else
      return ptr + 1'b1;
  endfunction

  assign full  = (count == CNT_MAX);
  assign empty = (count == '0);

  // A held request keeps its owner even if the other side now asks, so the
  // bus request never changes under the bridge before it is accepted.
  assign grant = locked ? lock_id : (data_req ? ID_DATA : ID_INST);

  // resetn gating keeps every handshake output low while reset is applied.
  assign sram_req = resetn & ~full & (locked | data_req | inst_req);
  assign push     = sram_req & sram_addr_ok;
  assign pop      = resetn & sram_data_ok & ~empty;
  assign head_id  = id_fifo[head];

  assign inst_addr_ok = push & (grant == ID_INST);
  assign data_addr_ok = push & (grant == ID_DATA);

  assign inst_data_ok = pop & (head_id == ID_INST);
  assign data_data_ok = pop & (head_id == ID_DATA);

  assign inst_rdata = sram_rdata;
  assign data_rdata = sram_rdata;

  assign err_unexp = err_q & resetn;

  always_comb begin
    sram_wr    = 1'b0;
    sram_size  = '0;
    sram_wstrb = '0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (sram_req) begin
      if (grant == ID_DATA) begin
        sram_wr    = data_wr;
        sram_size  = data_size;
        sram_wstrb = data_wstrb;
        sram_addr  = data_addr;
        sram_wdata = data_wdata;
      end else begin
        sram_wr    = inst_wr;
        sram_size  = inst_size;
        sram_wstrb = inst_wstrb;
        sram_addr  = inst_addr;
        sram_wdata = inst_wdata;
      end
    end
  end

  // While full, sram_req is low and the lock simply holds its value.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      locked  <= 1'b0;
      lock_id <= ID_INST;
    end else if (sram_req) begin
      locked  <= ~sram_addr_ok;
      lock_id <= grant;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      id_fifo <= '0;
      err_q   <= 1'b0;
    end else begin
      if (push) begin
        id_fifo[tail] <= grant;
        tail          <= next_ptr(tail);
      end
      if (pop)
        head <= next_ptr(head);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (sram_data_ok && empty)
        err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Testbench for sram_req_arbiter: directed scenarios followed by randomized
// traffic, all checked against a queue-based model of outstanding requests.
module tb_sram_req_arbiter;

  localparam int MAX_OUTST = 2;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        inst_req = 0, inst_wr = 0;
  logic [1:0]  inst_size = 0;
  logic [3:0]  inst_wstrb = 0;
  logic [31:0] inst_addr = 0, inst_wdata = 0;
  logic        data_req = 0, data_wr = 0;
  logic [1:0]  data_size = 0;
  logic [3:0]  data_wstrb = 0;
  logic [31:0] data_addr = 0, data_wdata = 0;
  logic        sram_addr_ok = 0, sram_data_ok = 0;
  logic [31:0] sram_rdata = 0;

  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        sram_req, sram_wr;
  logic [1:0]  sram_size;
  logic [3:0]  sram_wstrb;
  logic [31:0] sram_addr, sram_wdata;
  logic        err_unexp;

  always #5 clk = ~clk;

  sram_req_arbiter #(.MAX_OUTST(MAX_OUTST), .CNT_W(2)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .sram_req(sram_req), .sram_wr(sram_wr), .sram_size(sram_size), .sram_wstrb(sram_wstrb),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_addr_ok(sram_addr_ok), .sram_data_ok(sram_data_ok), .sram_rdata(sram_rdata),
    .err_unexp(err_unexp)
  );

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model: owners of accepted-but-unanswered requests (0 inst, 1 data),
  // the requester currently waiting on the bus, and the sticky error.
  int q[$];
  bit pend_v = 0;
  int pend_id = 0;
  bit err_m = 0;

  bit e_req;
  bit e_pop;
  int e_grant;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_idle();
    inst_req = 0; inst_wr = 0; inst_size = 0; inst_wstrb = 0; inst_addr = 0; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = 0; data_wstrb = 0; data_addr = 0; data_wdata = 0;
    sram_addr_ok = 0; sram_data_ok = 0; sram_rdata = 0;
  endtask

  task automatic sample_and_check();
    logic [70:0] e_bus;
    bit full;
    int head;
    #1;
    full    = (q.size() == MAX_OUTST);
    head    = (q.size() > 0) ? q[0] : 0;
    e_grant = pend_v ? pend_id : (data_req ? 1 : 0);
    e_req   = resetn && !full && (pend_v || data_req || inst_req);
    e_pop   = resetn && sram_data_ok && (q.size() > 0);
    if (!e_req)
      e_bus = '0;
    else if (e_grant == 1)
      e_bus = {data_wr, data_size, data_wstrb, data_addr, data_wdata};
    else
      e_bus = {inst_wr, inst_size, inst_wstrb, inst_addr, inst_wdata};
    check_val("sram_req", sram_req, e_req);
    check_val("sram_bus", {sram_wr, sram_size, sram_wstrb, sram_addr, sram_wdata}, e_bus);
    check_val("inst_addr_ok", inst_addr_ok, e_req && sram_addr_ok && e_grant == 0);
    check_val("data_addr_ok", data_addr_ok, e_req && sram_addr_ok && e_grant == 1);
    check_val("inst_data_ok", inst_data_ok, e_pop && head == 0);
    check_val("data_data_ok", data_data_ok, e_pop && head == 1);
    check_val("err_unexp", err_unexp, resetn && err_m);
    if (resetn) begin
      check_val("inst_rdata", inst_rdata, sram_rdata);
      check_val("data_rdata", data_rdata, sram_rdata);
    end
  endtask

  task automatic advance();
    @(posedge clk);
    if (!resetn) begin
      q.delete();
      pend_v = 0;
      err_m  = 0;
    end else begin
      if (sram_data_ok && q.size() == 0) err_m = 1;
      if (e_pop) void'(q.pop_front());
      if (e_req) begin
        if (sram_addr_ok) begin
          q.push_back(e_grant);
          pend_v = 0;
        end else begin
          pend_v  = 1;
          pend_id = e_grant;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic cycle();
    sample_and_check();
    advance();
  endtask

  initial begin
    set_idle();
    resetn = 0;
    cycle();
    cycle();
    resetn = 1;
    cycle();

    // Response with nothing outstanding.
    sram_data_ok = 1; sram_rdata = 32'h1234_5678;
    cycle();
    set_idle();
    sample_and_check();
    check_val("err_sticky", err_unexp, 1'b1);
    advance();
    cycle();
    resetn = 0;
    sample_and_check();
    check_val("err_rst_low", err_unexp, 1'b0);
    advance();
    resetn = 1;
    cycle();

    // Single inst fetch.
    inst_req = 1; inst_addr = 32'h1C00_0000; inst_size = 2'd2; sram_addr_ok = 1;
    sample_and_check();
    check_val("if_addr_ok", inst_addr_ok, 1'b1);
    check_val("if_sram_addr", sram_addr, 32'h1C00_0000);
    advance();
    set_idle();
    sram_data_ok = 1; sram_rdata = 32'h0280_0C0C;
    sample_and_check();
    check_val("if_data_ok", inst_data_ok, 1'b1);
    check_val("if_rdata", inst_rdata, 32'h0280_0C0C);
    check_val("if_no_data_ok", data_data_ok, 1'b0);
    advance();
    set_idle();

    // Both request together: data first, then inst.
    inst_req = 1; inst_addr = 32'h1C00_0004;
    data_req = 1; data_addr = 32'h8000_0010; data_wr = 1; data_wstrb = 4'hF; data_wdata = 32'hCAFE_F00D;
    sram_addr_ok = 1;
    sample_and_check();
    check_val("prio_data", data_addr_ok, 1'b1);
    advance();
    data_req = 0; data_wr = 0;
    sample_and_check();
    check_val("prio_inst", inst_addr_ok, 1'b1);
    advance();
    set_idle();
    sram_data_ok = 1; sram_rdata = 32'hAAAA_0001;
    sample_and_check();
    check_val("order_data", data_data_ok, 1'b1);
    advance();
    sram_rdata = 32'hBBBB_0002;
    sample_and_check();
    check_val("order_inst", inst_data_ok, 1'b1);
    advance();
    set_idle();

    // Lock: waiting inst request is not preempted by a later data request.
    inst_req = 1; inst_addr = 32'h1C00_0100;
    cycle();
    data_req = 1; data_addr = 32'h8000_0200;
    sample_and_check();
    check_val("lock_addr1", sram_addr, 32'h1C00_0100);
    advance();
    sample_and_check();
    check_val("lock_addr2", sram_addr, 32'h1C00_0100);
    advance();
    sram_addr_ok = 1;
    sample_and_check();
    check_val("lock_accept", inst_addr_ok, 1'b1);
    advance();
    inst_req = 0;
    sample_and_check();
    check_val("lock_then_data", data_addr_ok, 1'b1);
    advance();
    set_idle();
    sram_data_ok = 1;
    cycle();
    cycle();
    set_idle();

    // Full: two accepts block issue until a response frees a slot.
    inst_req = 1; inst_addr = 32'h1C00_0300; sram_addr_ok = 1;
    cycle();
    cycle();
    sample_and_check();
    check_val("full_block", sram_req, 1'b0);
    advance();
    sram_data_ok = 1;
    sample_and_check();
    check_val("full_block_pop", sram_req, 1'b0);
    advance();
    sram_data_ok = 0;
    sample_and_check();
    check_val("full_resume", sram_req, 1'b1);
    advance();
    sram_data_ok = 1;
    cycle();
    sram_data_ok = 0;
    sample_and_check();
    check_val("push_pop_cnt", sram_req, 1'b1);
    advance();
    set_idle();
    sram_data_ok = 1;
    cycle();
    cycle();
    set_idle();

    // Reset with a request outstanding and the lock set.
    inst_req = 1; inst_addr = 32'h1C00_0400; sram_addr_ok = 1;
    cycle();
    sram_addr_ok = 0;
    cycle();
    resetn = 0;
    cycle();
    resetn = 1;
    set_idle();
    sample_and_check();
    check_val("rst_no_req", sram_req, 1'b0);
    advance();
    data_req = 1; data_addr = 32'h8000_0400;
    sample_and_check();
    check_val("rst_follow", sram_addr, 32'h8000_0400);
    advance();
    set_idle();
    sram_data_ok = 1;
    cycle();
    set_idle();
    sample_and_check();
    check_val("rst_inflight_err", err_unexp, 1'b1);
    advance();
    resetn = 0;
    cycle();
    resetn = 1;

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      resetn       = ($urandom_range(0, 499) != 0);
      inst_req     = ($urandom_range(0, 99) < 55);
      inst_wr      = ($urandom_range(0, 19) == 0);
      inst_size    = 2'($urandom);
      inst_wstrb   = 4'($urandom);
      inst_addr    = $urandom;
      inst_wdata   = $urandom;
      data_req     = ($urandom_range(0, 99) < 45);
      data_wr      = 1'($urandom);
      data_size    = 2'($urandom);
      data_wstrb   = 4'($urandom);
      data_addr    = $urandom;
      data_wdata   = $urandom;
      sram_addr_ok = 1'($urandom);
      if (q.size() > 0)
        sram_data_ok = 1'($urandom);
      else
        sram_data_ok = ($urandom_range(0, 299) == 0);
      sram_rdata   = $urandom;
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
